// File: rtl/fifo_pkg.sv
// Shared constants and types for the 128x8 packet FIFO.
// Read and write controllers both import this package.
package fifo_pkg;

    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned DATA_W = 8;

    // The extra top bit is the wrap bit that tells full apart from empty.
    typedef logic [ADDR_W:0] ptr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } rd_state_t;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// FIFO pointer counter with a wrap bit.
// It increments modulo 2^W and can load a new value; load wins over increment.
module fifo_ptr_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the packet FIFO.
// It owns the read pointer, tracks occupancy, and drives a registered valid/ready byte output.
module fifo_rd_ctrl
    import fifo_pkg::*;
(
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic [ADDR_W:0]   w_ptr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] r_count,
    output logic [ADDR_W:0]   r_ptr,
    output logic              empty,
    output logic [ADDR_W:0]   occupancy,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_data,
    input  logic              flush,
    output logic              ptr_err
);

    localparam ptr_t DEPTH_CNT = ptr_t'(DEPTH);

    rd_state_t state_q, state_d;
    logic      pop;
    logic      overrun;

    assign occupancy = w_ptr - r_ptr;
    assign empty     = (occupancy == '0);
    assign overrun   = (occupancy > DEPTH_CNT);
    assign r_count   = r_ptr[ADDR_W-1:0];
    assign r_valid   = (state_q == VALID);

    // The output register may refill whenever it is empty or being drained this cycle.
    assign pop = !empty && (!r_valid || r_ready) && !flush;

    fifo_ptr_cnt #(
        .W (ADDR_W + 1)
    ) u_rd_ptr (
        .clk      (r_clk),
        .rst      (r_rst),
        .inc      (pop),
        .load     (flush),
        .load_val (w_ptr),
        .ptr      (r_ptr)
    );

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (pop) begin
            state_d = VALID;
        end else if (r_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state_q <= IDLE;
            r_data  <= '0;
            ptr_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                r_data <= mem_data;
            end
            // Sticky until flush; flush clears it even if the overrun persists.
            if (flush) begin
                ptr_err <= 1'b0;
            end else if (overrun) begin
                ptr_err <= 1'b1;
            end
        end
    end

endmodule
